moo_iv_ctx: RTL and testbench

Multi-context IV/counter store for the mode-of-operation (MOO) datapath. It holds NCTX independent IV slots, each tagged with its own 3-bit mode. After every processed block it advances the selected slot: feedback capture for CBC, OFB and CFB, and a counter increment for CTR, CCM and GCM. It sits between the command decoder, which loads IVs, and the block-cipher core, which reads IVs and returns feedback. This lets several sessions interleave without reloading the IV.

---
 rtl/moo_iv_ctx_if.sv | 39 +++
 rtl/moo_iv_ctx.sv | 187 ++++++++++++++++++
 tb/tb_moo_iv_ctx.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/moo_iv_ctx_if.sv
// Command, core-feedback and read bus of the multi-context IV store.
// slave: the store itself; master: the command decoder / cipher core side.
interface moo_iv_ctx_if #(
  parameter int unsigned NCTX = 4,
  parameter int unsigned DW   = 128
);
  localparam int unsigned CXW = $clog2(NCTX);

  logic            clr_core;
  logic            ld_en;
  logic [CXW-1:0]  ld_ctx;
  logic [2:0]      ld_mode;
  logic [DW-1:0]   ld_iv;
  logic            upd_en;
  logic [CXW-1:0]  upd_ctx;
  logic [DW-1:0]   upd_fb;
  logic            inv_en;
  logic [CXW-1:0]  inv_ctx;
  logic            rd_en;
  logic [CXW-1:0]  rd_ctx;
  logic            rd_vld;
  logic [DW-1:0]   rd_iv;
  logic [2:0]      rd_mode;
  logic [NCTX-1:0] ctx_vld;
  logic [NCTX-1:0] cnt_wrap;
  logic            err;

  modport slave (
    input  clr_core, ld_en, ld_ctx, ld_mode, ld_iv,
    input  upd_en, upd_ctx, upd_fb, inv_en, inv_ctx, rd_en, rd_ctx,
    output rd_vld, rd_iv, rd_mode, ctx_vld, cnt_wrap, err
  );

  modport master (
    output clr_core, ld_en, ld_ctx, ld_mode, ld_iv,
    output upd_en, upd_ctx, upd_fb, inv_en, inv_ctx, rd_en, rd_ctx,
    input  rd_vld, rd_iv, rd_mode, ctx_vld, cnt_wrap, err
  );
endinterface

// File: rtl/moo_iv_ctx.sv
// Multi-context IV/counter store: per-slot mode tag, feedback capture or counter advance.
// Optional MOO_IV_CTR_SAT_EN: counters saturate at all-ones (flagging err) instead of wrapping.
module moo_iv_ctx #(
  parameter int unsigned NCTX = 4,
  parameter int unsigned DW   = 128,
  parameter int unsigned CW   = 32
) (
  input logic         clk,
  input logic         rst_n,
  moo_iv_ctx_if.slave bus
);
  localparam int unsigned CXW = $clog2(NCTX);

  localparam logic [2:0] ModeCbc = 3'b010;
  localparam logic [2:0] ModeOfb = 3'b011;
  localparam logic [2:0] ModeCfb = 3'b100;
  localparam logic [2:0] ModeCtr = 3'b101;
  localparam logic [2:0] ModeCcm = 3'b110;
  localparam logic [2:0] ModeGcm = 3'b111;

  logic [DW-1:0]   r_slot [NCTX];
  logic [2:0]      r_mode [NCTX];
  logic [NCTX-1:0] r_vld;
  logic [NCTX-1:0] r_wrap;
  logic [DW-1:0]   r_rd_iv;
  logic [2:0]      r_rd_mode;
  logic            r_rd_vld;
  logic            r_err;

  logic [DW-1:0]   w_slot_d [NCTX];
  logic [2:0]      w_mode_d [NCTX];
  logic [NCTX-1:0] w_vld_d;
  logic [NCTX-1:0] w_wrap_d;
  logic [DW-1:0]   w_rd_iv_d;
  logic [2:0]      w_rd_mode_d;
  logic            w_rd_vld_d;
  logic            w_err_d;

  logic [NCTX-1:0] w_ld_hit;
  logic [NCTX-1:0] w_inv_hit;
  logic [NCTX-1:0] w_upd_hit;
  logic [CW-1:0]   w_cnt_inc [NCTX];
  logic [NCTX-1:0] w_cnt_max;

  logic w_ld_ok;
  logic w_upd_ok;
  logic w_inv_ok;
  logic w_rd_ok;

  // With a power-of-two context count every index is legal.
  if (NCTX == (1 << CXW)) begin : g_pow2
    assign w_ld_ok  = 1'b1;
    assign w_upd_ok = 1'b1;
    assign w_inv_ok = 1'b1;
    assign w_rd_ok  = 1'b1;
  end else begin : g_npow2
    assign w_ld_ok  = (32'(bus.ld_ctx)  < NCTX);
    assign w_upd_ok = (32'(bus.upd_ctx) < NCTX);
    assign w_inv_ok = (32'(bus.inv_ctx) < NCTX);
    assign w_rd_ok  = (32'(bus.rd_ctx)  < NCTX);
  end

  always_comb begin
    for (int unsigned c = 0; c < NCTX; c++) begin
      w_ld_hit[c]  = bus.ld_en  && (bus.ld_ctx  == CXW'(c));
      w_inv_hit[c] = bus.inv_en && (bus.inv_ctx == CXW'(c));
      w_upd_hit[c] = bus.upd_en && (bus.upd_ctx == CXW'(c));
      w_cnt_inc[c] = r_slot[c][CW-1:0] + CW'(1);
      w_cnt_max[c] = &r_slot[c][CW-1:0];
    end
  end

  always_comb begin
    w_vld_d  = r_vld;
    w_wrap_d = r_wrap;
    w_err_d  = 1'b0;
    for (int unsigned c = 0; c < NCTX; c++) begin
      w_slot_d[c] = r_slot[c];
      w_mode_d[c] = r_mode[c];
    end

    if ((bus.ld_en && !w_ld_ok) || (bus.upd_en && !w_upd_ok) ||
        (bus.inv_en && !w_inv_ok) || (bus.rd_en && !w_rd_ok)) begin
      w_err_d = 1'b1;
    end

    // Per slot: load beats invalidate beats update; a losing op flags err.
    for (int unsigned c = 0; c < NCTX; c++) begin
      if (w_ld_hit[c]) begin
        w_slot_d[c] = bus.ld_iv;
        w_mode_d[c] = bus.ld_mode;
        w_vld_d[c]  = 1'b1;
        w_wrap_d[c] = 1'b0;
        if (w_inv_hit[c] || w_upd_hit[c]) begin
          w_err_d = 1'b1;
        end
      end else if (w_inv_hit[c]) begin
        w_vld_d[c]  = 1'b0;
        w_wrap_d[c] = 1'b0;
        if (w_upd_hit[c]) begin
          w_err_d = 1'b1;
        end
      end else if (w_upd_hit[c]) begin
        if (!r_vld[c]) begin
          w_err_d = 1'b1;
        end else begin
          case (r_mode[c])
            ModeCbc, ModeOfb, ModeCfb: w_slot_d[c] = bus.upd_fb;
            ModeCtr, ModeCcm, ModeGcm: begin
              if (w_cnt_max[c]) begin
                w_wrap_d[c] = 1'b1;
`ifdef MOO_IV_CTR_SAT_EN
                w_err_d = 1'b1;
`else
                w_slot_d[c][CW-1:0] = '0;
`endif
              end else begin
                w_slot_d[c][CW-1:0] = w_cnt_inc[c];
              end
            end
            default: ;
          endcase
        end
      end
    end

    // Reads see the state before this cycle's writes.
    w_rd_vld_d  = 1'b0;
    w_rd_iv_d   = r_rd_iv;
    w_rd_mode_d = r_rd_mode;
    if (bus.rd_en && w_rd_ok) begin
      w_rd_vld_d = 1'b1;
      if (r_vld[bus.rd_ctx]) begin
        w_rd_iv_d   = r_slot[bus.rd_ctx];
        w_rd_mode_d = r_mode[bus.rd_ctx];
      end else begin
        w_rd_iv_d   = '0;
        w_rd_mode_d = '0;
        w_err_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NCTX; c++) begin
        r_slot[c] <= '0;
        r_mode[c] <= '0;
      end
      r_vld     <= '0;
      r_wrap    <= '0;
      r_rd_iv   <= '0;
      r_rd_mode <= '0;
      r_rd_vld  <= 1'b0;
      r_err     <= 1'b0;
    end else if (bus.clr_core) begin
      for (int unsigned c = 0; c < NCTX; c++) begin
        r_slot[c] <= '0;
        r_mode[c] <= '0;
      end
      r_vld     <= '0;
      r_wrap    <= '0;
      r_rd_iv   <= '0;
      r_rd_mode <= '0;
      r_rd_vld  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < NCTX; c++) begin
        r_slot[c] <= w_slot_d[c];
        r_mode[c] <= w_mode_d[c];
      end
      r_vld     <= w_vld_d;
      r_wrap    <= w_wrap_d;
      r_rd_iv   <= w_rd_iv_d;
      r_rd_mode <= w_rd_mode_d;
      r_rd_vld  <= w_rd_vld_d;
      r_err     <= w_err_d;
    end
  end

  assign bus.rd_vld   = r_rd_vld;
  assign bus.rd_iv    = r_rd_iv;
  assign bus.rd_mode  = r_rd_mode;
  assign bus.ctx_vld  = r_vld;
  assign bus.cnt_wrap = r_wrap;
  assign bus.err      = r_err;
endmodule

// File: tb/tb_moo_iv_ctx.sv
// Scoreboard bench for moo_iv_ctx: driver pushes model predictions, monitor pops and compares.
module tb_moo_iv_ctx;
  localparam int unsigned NCTX = 4;
  localparam int unsigned DW   = 128;
  localparam int unsigned CW   = 32;
  localparam int unsigned CXW  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  moo_iv_ctx_if #(.NCTX(NCTX), .DW(DW)) bus ();
  moo_iv_ctx #(.NCTX(NCTX), .DW(DW), .CW(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    bit          clr;
    bit          ld;
    int          ld_ctx;
    bit [2:0]    ld_mode;
    bit [DW-1:0] ld_iv;
    bit          upd;
    int          upd_ctx;
    bit [DW-1:0] fb;
    bit          inv;
    int          inv_ctx;
    bit          rd;
    int          rd_ctx;
  } stim_t;

  typedef struct {
    bit            rd_vld;
    bit [DW-1:0]   rd_iv;
    bit [2:0]      rd_mode;
    bit [NCTX-1:0] vld;
    bit [NCTX-1:0] wrap;
    bit            err;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference state: what each context holds according to the behavioural rules.
  bit [DW-1:0] m_slot [NCTX];
  bit [2:0]    m_mode [NCTX];
  bit          m_vld  [NCTX];
  bit          m_wrap [NCTX];
  bit [DW-1:0] m_rd_iv;
  bit [2:0]    m_rd_mode;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NCTX; c++) begin
      m_slot[c] = '0;
      m_mode[c] = '0;
      m_vld[c]  = 1'b0;
      m_wrap[c] = 1'b0;
    end
    m_rd_iv   = '0;
    m_rd_mode = '0;
  endfunction

  function automatic void model_step(input stim_t s, output exp_t e);
    bit err = 1'b0;
    bit rdv = 1'b0;
    bit [DW-1:0] lim = (DW'(1) << CW);
    bit [DW-1:0] lo;
    bit [DW-1:0] hi;
    bit [DW-1:0] nlo;
    if (s.clr) begin
      model_reset();
    end else begin
      if (s.rd) begin
        rdv = 1'b1;
        if (m_vld[s.rd_ctx]) begin
          m_rd_iv   = m_slot[s.rd_ctx];
          m_rd_mode = m_mode[s.rd_ctx];
        end else begin
          m_rd_iv   = '0;
          m_rd_mode = '0;
          err       = 1'b1;
        end
      end
      if (s.ld && s.inv && s.ld_ctx == s.inv_ctx) err = 1'b1;
      if (s.upd) begin
        if ((s.ld && s.ld_ctx == s.upd_ctx) || (s.inv && s.inv_ctx == s.upd_ctx) ||
            !m_vld[s.upd_ctx]) begin
          err = 1'b1;
        end else if (m_mode[s.upd_ctx] inside {3'd2, 3'd3, 3'd4}) begin
          m_slot[s.upd_ctx] = s.fb;
        end else if (m_mode[s.upd_ctx] >= 3'd5) begin
          lo  = m_slot[s.upd_ctx] % lim;
          hi  = m_slot[s.upd_ctx] - lo;
          nlo = (lo + 1) % lim;
          if (nlo == 0) begin
            m_wrap[s.upd_ctx] = 1'b1;
`ifdef MOO_IV_CTR_SAT_EN
            nlo = lim - 1;
            err = 1'b1;
`endif
          end
          m_slot[s.upd_ctx] = hi + nlo;
        end
      end
      if (s.inv && !(s.ld && s.ld_ctx == s.inv_ctx)) begin
        m_vld[s.inv_ctx]  = 1'b0;
        m_wrap[s.inv_ctx] = 1'b0;
      end
      if (s.ld) begin
        m_slot[s.ld_ctx] = s.ld_iv;
        m_mode[s.ld_ctx] = s.ld_mode;
        m_vld[s.ld_ctx]  = 1'b1;
        m_wrap[s.ld_ctx] = 1'b0;
      end
    end
    e.rd_vld  = rdv;
    e.rd_iv   = m_rd_iv;
    e.rd_mode = m_rd_mode;
    e.err     = err;
    for (int c = 0; c < NCTX; c++) begin
      e.vld[c]  = m_vld[c];
      e.wrap[c] = m_wrap[c];
    end
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  task automatic drive(input stim_t s);
    bus.clr_core = s.clr;
    bus.ld_en    = s.ld;
    bus.ld_ctx   = CXW'(s.ld_ctx);
    bus.ld_mode  = s.ld_mode;
    bus.ld_iv    = s.ld_iv;
    bus.upd_en   = s.upd;
    bus.upd_ctx  = CXW'(s.upd_ctx);
    bus.upd_fb   = s.fb;
    bus.inv_en   = s.inv;
    bus.inv_ctx  = CXW'(s.inv_ctx);
    bus.rd_en    = s.rd;
    bus.rd_ctx   = CXW'(s.rd_ctx);
  endtask

  task automatic cyc(input stim_t s);
    exp_t e;
    @(negedge clk);
    drive(s);
    model_step(s, e);
    q.push_back(e);
  endtask

  task automatic ld(input int c, input bit [2:0] m, input bit [DW-1:0] iv);
    stim_t s = idle();
    s.ld = 1; s.ld_ctx = c; s.ld_mode = m; s.ld_iv = iv;
    cyc(s);
  endtask

  task automatic upd(input int c, input bit [DW-1:0] fb);
    stim_t s = idle();
    s.upd = 1; s.upd_ctx = c; s.fb = fb;
    cyc(s);
  endtask

  task automatic rd(input int c);
    stim_t s = idle();
    s.rd = 1; s.rd_ctx = c;
    cyc(s);
  endtask

  task automatic chk_zero();
    chk("rst_rd_vld", bus.rd_vld, 0);
    chk("rst_rd_iv", bus.rd_iv, 0);
    chk("rst_rd_mode", bus.rd_mode, 0);
    chk("rst_ctx_vld", bus.ctx_vld, 0);
    chk("rst_cnt_wrap", bus.cnt_wrap, 0);
    chk("rst_err", bus.err, 0);
  endtask

  // Monitor: every captured cycle has exactly one prediction waiting.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && q.size() > 0) begin
        e = q.pop_front();
        chk("rd_vld", bus.rd_vld, e.rd_vld);
        chk("rd_iv", bus.rd_iv, e.rd_iv);
        chk("rd_mode", bus.rd_mode, e.rd_mode);
        chk("ctx_vld", bus.ctx_vld, e.vld);
        chk("cnt_wrap", bus.cnt_wrap, e.wrap);
        chk("err", bus.err, e.err);
      end
    end
  end

  initial begin
    stim_t s;
    drive(idle());
    model_reset();
    #1 rst_n = 1'b0;
    #1 chk_zero();
    @(negedge clk);
    rst_n = 1'b1;

    // Counter wrap on CTR.
    ld(0, 3'b101, {96'h0123_4567_89ab_cdef_0011_2233, 32'hFFFF_FFFE});
    upd(0, '0);
    upd(0, '0);
    rd(0);
    // CBC feedback capture.
    ld(1, 3'b010, {4{32'hAAAA_0001}});
    upd(1, {4{32'hBBBB_0002}});
    rd(1);
    // Same-cycle load/update/read collision on ctx2.
    ld(2, 3'b011, {4{32'h5A5A_0003}});
    s = idle();
    s.ld = 1; s.ld_ctx = 2; s.ld_mode = 3'b100; s.ld_iv = {4{32'hCCCC_0004}};
    s.upd = 1; s.upd_ctx = 2; s.fb = {4{32'hDDDD_0005}};
    s.rd = 1; s.rd_ctx = 2;
    cyc(s);
    rd(2);
    // Update and read of a never-loaded context.
    upd(3, {4{32'hEEEE_0006}});
    rd(3);
    // Four distinct modes, interleaved advances, ECB untouched.
    ld(0, 3'b111, {96'h1, 32'h0000_00FF});
    ld(1, 3'b011, {4{32'h1111_1111}});
    ld(2, 3'b001, {4{32'h2222_2222}});
    ld(3, 3'b110, {96'h3, 32'h7FFF_FFFF});
    upd(0, '0);
    upd(3, '0);
    upd(0, '0);
    upd(2, {4{32'hFFFF_0000}});
    upd(1, {4{32'h9999_9999}});
    for (int c = 0; c < NCTX; c++) rd(c);
    // Invalidate then read back.
    s = idle(); s.inv = 1; s.inv_ctx = 1; cyc(s);
    rd(1);

    // Async reset mid-sequence, reload, then synchronous clear.
    cyc(idle());
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1 chk_zero();
    @(negedge clk);
    rst_n = 1'b1;
    ld(0, 3'b101, {4{32'h1234_5678}});
    ld(1, 3'b010, {4{32'h8765_4321}});
    rd(0);
    s = idle();
    s.clr = 1; s.ld = 1; s.ld_ctx = 2; s.ld_mode = 3'b111; s.ld_iv = '1; s.rd = 1; s.rd_ctx = 0;
    cyc(s);
    rd(0);

    // Random traffic, with counter fields biased towards the wrap point.
    for (int i = 0; i < 3000; i++) begin
      s = idle();
      s.clr     = ($urandom_range(0, 99) == 0);
      s.ld      = ($urandom_range(0, 3) == 0);
      s.ld_ctx  = $urandom_range(0, NCTX - 1);
      s.ld_mode = 3'($urandom_range(0, 7));
      s.ld_iv   = {$urandom(), $urandom(), $urandom(), $urandom()};
      case ($urandom_range(0, 3))
        0: s.ld_iv[31:0] = 32'hFFFF_FFFE;
        1: s.ld_iv[31:0] = 32'hFFFF_FFFF;
        default: ;
      endcase
      s.upd     = ($urandom_range(0, 1) == 0);
      s.upd_ctx = $urandom_range(0, NCTX - 1);
      s.fb      = {$urandom(), $urandom(), $urandom(), $urandom()};
      s.inv     = ($urandom_range(0, 7) == 0);
      s.inv_ctx = $urandom_range(0, NCTX - 1);
      s.rd      = ($urandom_range(0, 1) == 0);
      s.rd_ctx  = $urandom_range(0, NCTX - 1);
      cyc(s);
    end

    cyc(idle());
    repeat (2) @(negedge clk);
    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
